// File: rtl/rv32i_pkg.sv
// Shared constants and the debug handshake state type for the integer register file.
package rv32i_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_CAPT,
    DBG_ACK
  } dbg_state_t;
endpackage

// File: rtl/rv32i_regfile_dbg.sv
// Four-phase debug read port: latches the address on request, captures one register,
// then holds the acknowledge until the requester drops its request.
module rv32i_regfile_dbg
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dbg_req,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_data
);

  dbg_state_t            state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DBG_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DBG_IDLE && dbg_req) addr_q <= dbg_addr;
      if (state_q == DBG_CAPT) data_q <= rd_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DBG_IDLE: if (dbg_req) state_d = DBG_CAPT;
      DBG_CAPT: state_d = DBG_ACK;
      DBG_ACK:  if (!dbg_req) state_d = DBG_IDLE;
      default:  state_d = DBG_IDLE;
    endcase
  end

  // Ack decoded from the state register so an async reset drops it immediately.
  assign dbg_ack  = (state_q == DBG_ACK);
  assign rd_addr  = addr_q;
  assign dbg_data = data_q;

endmodule

// File: rtl/rv32i_regfile.sv
// 32 x XLEN integer register file: two combinational read ports with optional writeback
// forwarding, one write port, a debug read port and a committed-write counter.
module rv32i_regfile
  import rv32i_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_reg,
  input  logic [REG_ADDR_W-1:0] rs2_reg,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  dbg_req,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_data,
  output logic [CNT_W-1:0]      wr_count
);

  logic [XLEN-1:0]       regs [NREGS];
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] dbg_rd_addr;
  logic [XLEN-1:0]       dbg_rd_data;

  assign wr_en = wb_en && (wb_reg != REG_X0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cnt_q <= '0;
    end else if (wr_en) begin
      regs[wb_reg] <= wb_data;
      cnt_q        <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    rs1_data = (rs1_reg == REG_X0) ? '0 : regs[rs1_reg];
    rs2_data = (rs2_reg == REG_X0) ? '0 : regs[rs2_reg];
    if (BYPASS != 0 && wr_en && wb_reg == rs1_reg) rs1_data = wb_data;
    if (BYPASS != 0 && wr_en && wb_reg == rs2_reg) rs2_data = wb_data;
  end

  // The debug capture always sees the value the register holds after this cycle.
  always_comb begin
    dbg_rd_data = (dbg_rd_addr == REG_X0) ? '0 : regs[dbg_rd_addr];
    if (wr_en && wb_reg == dbg_rd_addr) dbg_rd_data = wb_data;
  end

  rv32i_regfile_dbg #(
    .XLEN(XLEN)
  ) u_dbg (
    .clk     (clk),
    .reset   (reset),
    .dbg_req (dbg_req),
    .dbg_addr(dbg_addr),
    .rd_addr (dbg_rd_addr),
    .rd_data (dbg_rd_data),
    .dbg_ack (dbg_ack),
    .dbg_data(dbg_data)
  );

  assign wr_count = cnt_q;

endmodule
